// File: rtl/risc_trace_pkg.sv
// Shared types and constants for the miniRISC result tracer.
package risc_trace_pkg;

    localparam int DATA_W   = 32;
    localparam int TS_W_DEF = 16;
    localparam int DROP_W   = 8;

    typedef struct packed {
        logic [DATA_W-1:0]   out1;
        logic [DATA_W-1:0]   out2;
        logic [TS_W_DEF-1:0] ts;
    } trace_entry_t;

    // Drop counter sticks at all-ones rather than wrapping back to zero.
    function automatic logic [DROP_W-1:0] sat_inc(input logic [DROP_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/risc_out_tracer_if.sv
// Read port of the trace FIFO: head entry presented with valid/ready.
interface risc_out_tracer_if #(
    parameter int TS_W = 16
);
    import risc_trace_pkg::*;

    logic              rd_valid;
    logic              rd_ready;
    logic [DATA_W-1:0] rd_out1;
    logic [DATA_W-1:0] rd_out2;
    logic [TS_W-1:0]   rd_ts;

    modport master (output rd_valid, rd_out1, rd_out2, rd_ts, input rd_ready);
    modport slave  (input rd_valid, rd_out1, rd_out2, rd_ts, output rd_ready);

endinterface

// File: rtl/risc_out_tracer_fifo.sv
// First-word-fall-through FIFO of trace entries. Full/empty come from the
// occupancy counter so the pointers can simply wrap.
module trace_fifo
    import risc_trace_pkg::*;
#(
    parameter int  DEPTH   = 16,
    parameter type entry_t = trace_entry_t
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clear,
    input  logic                   push,
    input  logic                   pop_req,
    input  entry_t                 wr_data,
    output entry_t                 rd_data,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    entry_t        mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          pop;
    logic          push_ok;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign pop     = pop_req && !empty;
    // A full FIFO still accepts a write when the head leaves in the same cycle.
    assign push_ok = push && (!full || pop);
    assign rd_data = empty ? '0 : mem[rd_ptr];

    // Pointers and occupancy; clear wins over any push/pop in its cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Entry storage; contents are don't-care while empty, so no reset.
    always_ff @(posedge clk) begin
        if (push_ok && !clear) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/risc_out_tracer.sv
// Watches the core result pair and logs each change with a timestamp into a
// FIFO that a host drains through a valid/ready port.
module risc_out_tracer
    import risc_trace_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int TS_W  = TS_W_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [DATA_W-1:0]      out1,
    input  logic [DATA_W-1:0]      out2,
    input  logic                   en,
    input  logic                   clear,
    risc_out_tracer_if.master      rd,
    output logic [$clog2(DEPTH):0] count,
    output logic                   overflow,
    output logic [DROP_W-1:0]      drop_cnt
);
    typedef struct packed {
        logic [DATA_W-1:0] out1;
        logic [DATA_W-1:0] out2;
        logic [TS_W-1:0]   ts;
    } entry_t;

    logic [TS_W-1:0]   ts;
    logic [DATA_W-1:0] prev1;
    logic [DATA_W-1:0] prev2;
    logic              capture;
    logic              do_pop;
    logic              push;
    logic              drop;
    logic              full;
    logic              empty;
    entry_t            wr_entry;
    entry_t            head;

    assign capture  = en && ((out1 != prev1) || (out2 != prev2));
    assign do_pop   = rd.rd_ready && !empty;
    assign push     = capture && !clear && (!full || do_pop);
    // A capture discarded by clear is not a drop.
    assign drop     = capture && !clear && full && !do_pop;
    assign wr_entry = '{out1: out1, out2: out2, ts: ts};

    assign rd.rd_valid = !empty;
    assign rd.rd_out1  = head.out1;
    assign rd.rd_out2  = head.out2;
    assign rd.rd_ts    = head.ts;

    // Free-running timestamp, untouched by clear and en.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) ts <= '0;
        else      ts <= ts + 1'b1;
    end

    // Last enabled pair; keeps loading during clear so a flushed change is not re-seen.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prev1 <= '0;
            prev2 <= '0;
        end else if (en) begin
            prev1 <= out1;
            prev2 <= out2;
        end
    end

    // Sticky overflow flag and saturating drop counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            overflow <= 1'b0;
            drop_cnt <= '0;
        end else if (clear) begin
            overflow <= 1'b0;
            drop_cnt <= '0;
        end else if (drop) begin
            overflow <= 1'b1;
            drop_cnt <= sat_inc(drop_cnt);
        end
    end

    trace_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (entry_t)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .clear   (clear),
        .push    (push),
        .pop_req (rd.rd_ready),
        .wr_data (wr_entry),
        .rd_data (head),
        .count   (count),
        .full    (full),
        .empty   (empty)
    );

endmodule

// File: tb/tb_risc_out_tracer.sv
// Directed bench for risc_out_tracer with hand-computed expectations.
module tb_risc_out_tracer;
    import risc_trace_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] out1;
    logic [31:0] out2;
    logic        en;
    logic        clear;
    logic [4:0]  count;
    logic        overflow;
    logic [7:0]  drop_cnt;

    int n_chk  = 0;
    int n_pass = 0;
    int ts_m   = 0;
    int t;

    risc_out_tracer_if #(.TS_W(16)) rd_if ();

    risc_out_tracer #(.DEPTH(16), .TS_W(16)) dut (
        .clk      (clk),
        .rst      (rst),
        .out1     (out1),
        .out2     (out2),
        .en       (en),
        .clear    (clear),
        .rd       (rd_if.master),
        .count    (count),
        .overflow (overflow),
        .drop_cnt (drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Advance one clock; ts_m tracks the timestamp of the cycle now in progress.
    task automatic step();
        @(posedge clk);
        #1;
        ts_m++;
    endtask

    task automatic pop_head(input int e1, input int e2, input int ets);
        chk("pop_valid", rd_if.rd_valid, 1);
        chk("pop_out1", rd_if.rd_out1, e1);
        chk("pop_out2", rd_if.rd_out2, e2);
        chk("pop_ts", rd_if.rd_ts, 16'(ets));
        rd_if.rd_ready = 1'b1;
        step();
        rd_if.rd_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b0; en = 1'b0; clear = 1'b0; out1 = '0; out2 = '0;
        rd_if.rd_ready = 1'b0;
        #2;
        chk("rst_valid", rd_if.rd_valid, 0);
        chk("rst_count", count, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_drop", drop_cnt, 0);
        chk("rst_out1", rd_if.rd_out1, 0);
        rst = 1'b1; ts_m = 0;
        en = 1'b1;

        // basic capture at ts=3
        step(); step(); step();
        out1 = 5;
        chk("t1_pre_valid", rd_if.rd_valid, 0);
        step();
        chk("t1_valid", rd_if.rd_valid, 1);
        chk("t1_ts", rd_if.rd_ts, 3);
        chk("t1_count", count, 1);
        step();
        chk("t1_hold_count", count, 1);
        pop_head(5, 0, 3);
        chk("t1_empty", rd_if.rd_valid, 0);

        // both outputs change, then one
        t = ts_m;
        out1 = 7; out2 = 9; step();
        out2 = 10; step();
        chk("t2_count", count, 2);
        pop_head(7, 9, t);
        pop_head(7, 10, t + 1);
        chk("t2_empty", rd_if.rd_valid, 0);

        // overflow and drop saturation
        t = ts_m;
        for (int i = 0; i < 19; i++) begin
            out1 = 100 + i; out2 = i; step();
        end
        chk("t3_count", count, 16);
        chk("t3_ovf", overflow, 1);
        chk("t3_drop", drop_cnt, 3);
        for (int i = 0; i < 260; i++) begin
            out1 = 1000 + i; step();
        end
        chk("t3_drop_sat", drop_cnt, 255);
        chk("t3_count_sat", count, 16);
        for (int i = 0; i < 16; i++) pop_head(100 + i, i, t + i);
        chk("t3_drained", rd_if.rd_valid, 0);
        chk("t3_ovf_sticky", overflow, 1);
        clear = 1'b1; step(); clear = 1'b0;
        chk("t3_clr_ovf", overflow, 0);
        chk("t3_clr_drop", drop_cnt, 0);

        // full with simultaneous push and pop
        t = ts_m;
        out2 = 0;
        for (int i = 0; i < 16; i++) begin
            out1 = 200 + i; step();
        end
        chk("t4_full", count, 16);
        rd_if.rd_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            out1 = 300 + i; step();
            chk("t4_count_loop", count, 16);
        end
        rd_if.rd_ready = 1'b0;
        chk("t4_ovf", overflow, 0);
        chk("t4_drop", drop_cnt, 0);
        chk("t4_head_out1", rd_if.rd_out1, 210);
        chk("t4_head_ts", rd_if.rd_ts, 16'(t + 10));

        // clear mid-stream with a change in the same cycle
        clear = 1'b1; step(); clear = 1'b0;
        chk("t5_flush", count, 0);
        for (int i = 0; i < 4; i++) begin
            out1 = 400 + i; step();
        end
        chk("t5_four", count, 4);
        clear = 1'b1; out1 = 500; step(); clear = 1'b0;
        chk("t5_count", count, 0);
        chk("t5_valid", rd_if.rd_valid, 0);
        chk("t5_drop", drop_cnt, 0);
        step();
        chk("t5_no_recap", count, 0);
        t = ts_m;
        out1 = 501; step();
        chk("t5_next", count, 1);
        pop_head(501, 0, t);

        // en gating
        en = 1'b0;
        out1 = 600; step();
        out1 = 601; step();
        out1 = 602; step();
        chk("t6_gated", count, 0);
        t = ts_m;
        en = 1'b1; step();
        chk("t6_count", count, 1);
        chk("t6_out1", rd_if.rd_out1, 602);
        chk("t6_ts", rd_if.rd_ts, 16'(t));

        // async reset between edges
        #3;
        rst = 1'b0;
        #1;
        chk("t6_rst_valid", rd_if.rd_valid, 0);
        chk("t6_rst_count", count, 0);
        chk("t6_rst_out1", rd_if.rd_out1, 0);
        chk("t6_rst_ts", rd_if.rd_ts, 0);
        #1;
        rst = 1'b1; ts_m = 0;
        step();
        chk("t6_first_nz", count, 1);
        chk("t6_first_out1", rd_if.rd_out1, 602);
        chk("t6_first_ts", rd_if.rd_ts, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/risc_out_tracer.md
# risc_out_tracer

Trace capture stage downstream of the miniRISC core. Watches the core's two 32-bit result outputs, `out1` and `out2`, every cycle. Whenever the pair changes, it pushes a timestamped entry into an internal FIFO. A bench or debug host drains the FIFO through a valid/ready port, so result sequences are checked in order without sampling at exact cycles.

## Interface
- `DEPTH`, 16: FIFO entries; power of two, ≥ 2.
- `TS_W`, 16: timestamp width in bits.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-low reset (0 = reset).
- `out1`  in  32  core result output 1.
- `out2`  in  32  core result output 2.
- `en`  in  1  capture enable.
- `clear`  in  1  synchronous flush.
- `rd_valid`  out  1  head entry available.
- `rd_ready`  in  1  consumer accepts head.
- `rd_out1`  out  32  head entry out1 value.
- `rd_out2`  out  32  head entry out2 value.
- `rd_ts`  out  TS_W  head entry timestamp.
- `count`  out  $clog2(DEPTH)+1  current occupancy.
- `overflow`  out  1  sticky; set when a capture is dropped.
- `drop_cnt`  out  8  dropped captures, saturating at 255.

## Operation
- **Timestamp counter** `ts`
  - Free-running; increments every cycle out of reset.
  - Wraps modulo 2^TS_W.
  - Not affected by `clear` or `en`.
- **Previous-pair registers** `prev1`, `prev2`
  - Reset to 0.
  - Load `out1`/`out2` every cycle with `en`=1; hold when `en`=0.
- **Capture condition**: `en`=1 and (`out1`≠`prev1` or `out2`≠`prev2`).
  - Entry = {`out1`, `out2`, `ts` of that cycle}.
  - At most one entry per cycle.
- **Push/pop rules**
  - Push is accepted when the FIFO is not full, or when a pop happens in the same cycle.
  - Otherwise the entry is dropped: `overflow` sets and `drop_cnt` increments (saturating).
  - Pop happens when `rd_valid` and `rd_ready` are both 1 in a cycle.
  - `rd_ready` while empty has no effect.
- **Occupancy**
  - `count` is +1 on push only, −1 on pop only, unchanged on both.
- **Head outputs**
  - First-word-fall-through: `rd_out1`/`rd_out2`/`rd_ts` show the head entry whenever `rd_valid`=1.
  - They are 0 when empty.
- **`clear`** has priority over push and pop in its cycle:
  - empties the FIFO;
  - zeroes `overflow` and `drop_cnt`;
  - still updates `prev1`/`prev2` per `en`;
  - discards a capture in the same cycle (not counted as a drop).

## Timing
- **Reset values**: all outputs 0, `count`=0, `ts`=0, `prev1`=`prev2`=0, FIFO empty.
- **Reset is asynchronous**: asserting it mid-operation flushes immediately, including while `rd_valid`=1.
- **Capture latency**: change seen in cycle N → `rd_valid`=1 and head valid from cycle N+1, provided the FIFO was empty.
- **Pop**: a pop in cycle N presents the next entry, or `rd_valid`=0, from cycle N+1.
- **Full with simultaneous push and pop**: both succeed, `count` stays at DEPTH, `overflow` unchanged.
- **Pointer wrap**: read/write pointers are $clog2(DEPTH) bits and wrap naturally; full/empty are derived from `count`.
- **Enable edge**: `en` low→high captures in the first enabled cycle if the pair differs from the values held since disable.
- **Nonzero first pair**: the first nonzero pair after reset is captured, because `prev` resets to 0.

## Structure
- **Shared package `risc_trace_pkg`**
  - `DATA_W`=32.
  - Typedef `trace_entry_t` {out1, out2, ts}, with `ts` width taken from a package default of 16.
  - Drop-counter width constant (8).
- **Sub-module `trace_fifo`**: a synchronous first-word-fall-through FIFO of `trace_entry_t`, holding the pointers, `count`, and full/empty logic.
- **Top level**: change detection, timestamp counter, overflow/drop logic and `clear` priority.

## Test plan
- **Basic capture**: reset, `en`=1, drive `out1`=5, `out2`=0 at ts=3, then hold → exactly one entry {5, 0, 3}; `rd_valid` rises one cycle later; `count`=1.
- **Both outputs change**: change `out1`=7 and `out2`=9 in one cycle, then `out2`=10 at the next cycle → two entries in order, consecutive timestamps; pop with `rd_ready`=1 → {7,9}, then {7,10}, then `rd_valid`=0.
- **Overflow**: keep `rd_ready`=0 with DEPTH+3 distinct consecutive pairs → `count`=16, `overflow`=1, `drop_cnt`=3; the first 16 entries drain intact.
- **Full with push and pop together**: at `count`=16, hold `rd_ready`=1 while changing the pair each cycle for 10 cycles → `count` stays 16, `overflow` stays 0.
- **`clear` mid-stream**: pulse `clear` with 4 entries present and a change in the same cycle → `count`=0, `rd_valid`=0, `drop_cnt`=0; the next change is captured normally.
- **`en` gating and async reset**: with `en`=0, change `out1` three times → no entries; raise `en` → one entry with the current pair. Assert `rst`=0 asynchronously between edges → all outputs 0 immediately.
